// File: rtl/calc_disp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | calc_disp_pkg                                                          |
// | Segment patterns and scan FSM state type shared by the display driver.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package calc_disp_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bcd_to_seg7                                                            |
// | Combinational BCD nibble to active-low 7-segment pattern; A-F = dash. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module bcd_to_seg7
  import calc_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg7_scan_driver                                                       |
// | 4-digit multiplexed display driver with frame-synchronous double       |
// | buffering and anti-ghosting blanking. LEAD_ZERO_BLANK_EN suppresses    |
// | leading zero digits.                                                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module seg7_scan_driver
  import calc_disp_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int BW           = 5
) (
  input  logic        clck,
  input  logic        reste,
  input  logic [1:0]  count,
  input  logic [15:0] bcd_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [BW-1:0] c_BLANK_LOAD = BW'(BLANK_CYCLES);
  localparam logic [BW-1:0] c_BLANK_LAST = BW'(1);

  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [15:0]   active_q, active_d;
  disp_state_t   state_q, state_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          w_chg;
  logic          w_wrap;
  logic [3:0]    w_nibble;
  logic [6:0]    w_dec_seg;
  logic [3:0]    w_lz;

  assign w_chg      = (count != cnt_q);
  assign w_wrap     = (cnt_q == 2'd3) && (count == 2'd0);
  assign w_nibble   = active_q[{cnt_q, 2'b00} +: 4];
  assign load_ready = ~pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;

  bcd_to_seg7 u_dec (
    .nibble (w_nibble),
    .seg    (w_dec_seg)
  );

  always_comb begin
    w_lz = 4'b0000;
`ifdef LEAD_ZERO_BLANK_EN
    // Zero run from the left; digit 0 always stays lit
    w_lz[3] = (active_q[15:12] == 4'd0);
    w_lz[2] = w_lz[3] && (active_q[11:8] == 4'd0);
    w_lz[1] = w_lz[2] && (active_q[7:4] == 4'd0);
`endif
  end

  always_comb begin
    cnt_d       = count;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    an_d        = 4'hF;
    seg_d       = SEG_OFF;

    // Commit and accept are exclusive: both key off the pre-edge pend_full
    if (w_wrap && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (load_valid && !pend_full_q) begin
      pend_d      = bcd_in;
      pend_full_d = 1'b1;
    end

    if (w_chg) begin
      state_d     = BLANK;
      blank_cnt_d = c_BLANK_LOAD;
    end else begin
      case (state_q)
        BLANK: begin
          if (blank_cnt_q == c_BLANK_LAST) begin
            state_d = DRIVE;
          end else begin
            blank_cnt_d = blank_cnt_q - c_BLANK_LAST;
          end
        end
        DRIVE: state_d = DRIVE;
      endcase
    end

    if (state_q == DRIVE && !w_lz[cnt_q]) begin
      an_d  = ~(4'b0001 << cnt_q);
      seg_d = w_dec_seg;
    end
  end

  always_ff @(posedge clck or posedge reste) begin
    if (reste) begin
      cnt_q       <= 2'd0;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
      active_q    <= 16'h0000;
      state_q     <= BLANK;
      blank_cnt_q <= c_BLANK_LOAD;
      an_q        <= 4'hF;
      seg_q       <= SEG_OFF;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_seg7_scan_driver                                                    |
// | Directed scoreboard bench for seg7_scan_driver (honours               |
// | LEAD_ZERO_BLANK_EN).                                                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_seg7_scan_driver;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clck = 1'b0;
  logic        reste = 1'b1;
  logic [1:0]  count = 2'd0;
  logic [15:0] bcd_in = 16'h0000;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    bit         chk_seg;
  } exp_t;

  exp_t sb[$];

  seg7_scan_driver #(.BLANK_CYCLES(16), .BW(5)) dut (
    .clck       (clck),
    .reste      (reste),
    .count      (count),
    .bcd_in     (bcd_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .an         (an),
    .seg        (seg)
  );

  always #5 clck = ~clck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clck);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] a, input logic [6:0] s, input bit cs);
    exp_t e;
    e.tag = tag;
    e.an = a;
    e.seg = s;
    e.chk_seg = cs;
    sb.push_back(e);
  endtask

  task automatic chk_disp();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    n_checks++;
    assert (an === e.an) else begin
      n_fail++;
      $error("FAIL %s an observed=%b expected=%b", e.tag, an, e.an);
    end
    if (e.chk_seg) begin
      n_checks++;
      assert (seg === e.seg) else begin
        n_fail++;
        $error("FAIL %s seg observed=%b expected=%b", e.tag, seg, e.seg);
      end
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    n_checks++;
    assert (load_ready === exp) else begin
      n_fail++;
      $error("FAIL %s load_ready observed=%b expected=%b", tag, load_ready, exp);
    end
  endtask

  // Change count, check the blank gap end, then the digit one cycle later
  task automatic show(input logic [1:0] c, input string tag, input logic [3:0] a,
                      input logic [6:0] s, input bit cs);
    count = c;
    push({tag, "_blank"}, 4'hF, 7'h7F, 1'b1);
    tick(17);
    chk_disp();
    push(tag, a, s, cs);
    tick(1);
    chk_disp();
  endtask

  initial begin
    tick(2);
    push("reset", 4'hF, 7'h7F, 1'b1);
    chk_disp();
    chk_ready("reset_ready", 1'b1);
    reste = 1'b0;

    push("d0_zero", 4'b1110, 7'b1000000, 1'b1);
    tick(40);
    chk_disp();
    show(2'd1, "d1_zero", LZB ? 4'hF : 4'b1101, 7'b1000000, !LZB);
    show(2'd2, "d2_zero", LZB ? 4'hF : 4'b1011, 7'b1000000, !LZB);
    show(2'd3, "d3_zero", LZB ? 4'hF : 4'b0111, 7'b1000000, !LZB);
    show(2'd0, "d0_zero2", 4'b1110, 7'b1000000, 1'b1);
    show(2'd1, "d1_zero2", LZB ? 4'hF : 4'b1101, 7'b1000000, !LZB);

    // First load, then a second one held while the buffer is full
    bcd_in = 16'h1234;
    load_valid = 1'b1;
    tick(1);
    chk_ready("ready_after_load", 1'b0);
    bcd_in = 16'h5678;
    tick(1);
    chk_ready("ready_held_full", 1'b0);
    show(2'd2, "d2_pre_commit", LZB ? 4'hF : 4'b1011, 7'b1000000, !LZB);
    show(2'd3, "d3_pre_commit", LZB ? 4'hF : 4'b0111, 7'b1000000, !LZB);
    chk_ready("ready_before_wrap", 1'b0);

    count = 2'd0;
    tick(1);
    chk_ready("ready_at_wrap", 1'b1);
    push("wrap_blank", 4'hF, 7'h7F, 1'b1);
    tick(1);
    chk_ready("ready_second_accept", 1'b0);
    chk_disp();
    load_valid = 1'b0;
    push("d0_four", 4'b1110, 7'b0011001, 1'b1);
    tick(16);
    chk_disp();
    show(2'd3, "d3_one", 4'b0111, 7'b1111001, 1'b1);
    show(2'd0, "d0_eight", 4'b1110, 7'b0000000, 1'b1);
    chk_ready("ready_after_commit2", 1'b1);

    // Count change in the last blank cycle restarts blanking
    count = 2'd1;
    tick(16);
    show(2'd2, "d2_restart", 4'b1011, 7'b0000010, 1'b1);

    bcd_in = 16'h00A0;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
    show(2'd3, "d3_five", 4'b0111, 7'b0010010, 1'b1);
    show(2'd0, "d0_a0", 4'b1110, 7'b1000000, 1'b1);
    show(2'd1, "d1_dash", 4'b1101, 7'b0111111, 1'b1);
    show(2'd2, "d2_a0", LZB ? 4'hF : 4'b1011, 7'b1000000, !LZB);
    show(2'd3, "d3_a0", LZB ? 4'hF : 4'b0111, 7'b1000000, !LZB);

    // Load presented in the wrap cycle itself
    bcd_in = 16'h9999;
    load_valid = 1'b1;
    count = 2'd0;
    tick(1);
    load_valid = 1'b0;
    chk_ready("ready_wrap_load", 1'b0);
    push("d0_not_yet", 4'b1110, 7'b1000000, 1'b1);
    tick(17);
    chk_disp();
    show(2'd1, "d1_still_dash", 4'b1101, 7'b0111111, 1'b1);
    show(2'd2, "d2_still_a0", LZB ? 4'hF : 4'b1011, 7'b1000000, !LZB);
    show(2'd3, "d3_still_a0", LZB ? 4'hF : 4'b0111, 7'b1000000, !LZB);
    show(2'd0, "d0_nine", 4'b1110, 7'b0010000, 1'b1);
    chk_ready("ready_after_commit3", 1'b1);
    show(2'd1, "d1_nine", 4'b1101, 7'b0010000, 1'b1);

    // Asynchronous reset mid-DRIVE with a pending load
    bcd_in = 16'h4321;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
    chk_ready("ready_before_reset", 1'b0);
    #3;
    reste = 1'b1;
    #1;
    push("async_reset", 4'hF, 7'h7F, 1'b1);
    chk_disp();
    chk_ready("async_reset_ready", 1'b1);
    tick(1);
    reste = 1'b0;
    push("post_rst_d1", LZB ? 4'hF : 4'b1101, 7'b1000000, !LZB);
    tick(18);
    chk_disp();
    show(2'd3, "post_rst_d3", LZB ? 4'hF : 4'b0111, 7'b1000000, !LZB);
    show(2'd0, "post_rst_d0", 4'b1110, 7'b1000000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
